// File: rtl/astro_pkg.sv
// Shared definitions for the asteroid/shot game blocks.
// Contents: direction codes, move_tiros FSM state codes, field size defaults,
// and the state-to-debug-code decoder.
package astro_pkg;

  localparam int COORD_W_DEF   = 4;
  localparam int MAX_COORD_DEF = 15;

  // Shot direction codes, clockwise starting from north (north is y-1).
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    ESPERA   = 3'd1,
    LE       = 3'd2,
    CAPTURA  = 3'd3,
    ESCREVE  = 3'd4,
    PROXIMO  = 3'd5,
    FIM      = 3'd6
  } estado_move_t;

  // Debug code: the state number, or F for an encoding outside the FSM.
  function automatic logic [3:0] estado_db(input estado_move_t s);
    case (s)
      INICIO:  estado_db = 4'h0;
      ESPERA:  estado_db = 4'h1;
      LE:      estado_db = 4'h2;
      CAPTURA: estado_db = 4'h3;
      ESCREVE: estado_db = 4'h4;
      PROXIMO: estado_db = 4'h5;
      FIM:     estado_db = 4'h6;
      default: estado_db = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/passo_tiro.sv
// One movement step of a shot: next position plus out-of-field flag.
// Ports: x, y, dir in; nx, ny out (unchanged when fora); fora = step leaves the field.
// Purely combinational.
module passo_tiro
  import astro_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int MAX_COORD = MAX_COORD_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [2:0]         dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               fora
);

  localparam logic [COORD_W:0] ONE  = (COORD_W+1)'(1);
  localparam logic [COORD_W:0] MAXV = (COORD_W+1)'(MAX_COORD);

  logic inc_x, dec_x, inc_y, dec_y;
  logic [COORD_W:0] ex, ey;

  always_comb begin
    inc_x = 1'b0;
    dec_x = 1'b0;
    inc_y = 1'b0;
    dec_y = 1'b0;
    case (dir)
      DIR_N:  dec_y = 1'b1;
      DIR_NE: begin inc_x = 1'b1; dec_y = 1'b1; end
      DIR_E:  inc_x = 1'b1;
      DIR_SE: begin inc_x = 1'b1; inc_y = 1'b1; end
      DIR_S:  inc_y = 1'b1;
      DIR_SW: begin dec_x = 1'b1; inc_y = 1'b1; end
      DIR_W:  dec_x = 1'b1;
      default: begin dec_x = 1'b1; dec_y = 1'b1; end
    endcase
  end

  // One extra bit: stepping below 0 wraps to the top of the wider range,
  // so a single "greater than MAX" compare catches both edges.
  always_comb begin
    ex = {1'b0, x};
    ey = {1'b0, y};
    if (inc_x) ex = {1'b0, x} + ONE;
    if (dec_x) ex = {1'b0, x} - ONE;
    if (inc_y) ey = {1'b0, y} + ONE;
    if (dec_y) ey = {1'b0, y} - ONE;
    fora = (ex > MAXV) || (ey > MAXV);
    nx   = fora ? x : ex[COORD_W-1:0];
    ny   = fora ? y : ey[COORD_W-1:0];
  end

endmodule

// File: rtl/move_tiros.sv
// Moves every shot slot one step per start pulse via read-modify-write of the shot RAM.
// Ports: clock/reset, movimenta_tiro start in, fim_move_tiros done pulse out,
// mem_* RAM interface (sync read, 1-cycle latency), qtd_removidos count, debug state.
module move_tiros
  import astro_pkg::*;
#(
  parameter int N_TIROS   = 8,
  parameter int ADDR_W    = 3,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int MAX_COORD = MAX_COORD_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               movimenta_tiro,
  output logic               fim_move_tiros,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic               mem_wdata_ativo,
  output logic [COORD_W-1:0] mem_wdata_x,
  output logic [COORD_W-1:0] mem_wdata_y,
  output logic [2:0]         mem_wdata_dir,
  input  logic               mem_rdata_ativo,
  input  logic [COORD_W-1:0] mem_rdata_x,
  input  logic [COORD_W-1:0] mem_rdata_y,
  input  logic [2:0]         mem_rdata_dir,
  output logic [ADDR_W:0]    qtd_removidos,
  output logic [3:0]         db_estado_move_tiros
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_TIROS - 1);

  estado_move_t estado, prox_estado;

  logic [ADDR_W-1:0]  idx;
  logic               cap_ativo;
  logic [COORD_W-1:0] cap_x, cap_y;
  logic [2:0]         cap_dir;
  logic [ADDR_W:0]    qtd;

  logic [COORD_W-1:0] nx, ny;
  logic               fora;

  passo_tiro #(
    .COORD_W   (COORD_W),
    .MAX_COORD (MAX_COORD)
  ) u_passo (
    .x    (cap_x),
    .y    (cap_y),
    .dir  (cap_dir),
    .nx   (nx),
    .ny   (ny),
    .fora (fora)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIO;
    else       estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      INICIO:  prox_estado = ESPERA;
      ESPERA:  if (movimenta_tiro) prox_estado = LE;
      LE:      prox_estado = CAPTURA;
      CAPTURA: prox_estado = ESCREVE;
      ESCREVE: prox_estado = PROXIMO;
      PROXIMO: prox_estado = (idx == ULTIMO) ? FIM : LE;
      FIM:     prox_estado = ESPERA;
      default: prox_estado = INICIO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      cap_ativo <= 1'b0;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_dir   <= '0;
      qtd       <= '0;
    end else begin
      case (estado)
        ESPERA: if (movimenta_tiro) begin
          idx <= '0;
          qtd <= '0;
        end
        // RAM data for the address driven in LE is valid now.
        CAPTURA: begin
          cap_ativo <= mem_rdata_ativo;
          cap_x     <= mem_rdata_x;
          cap_y     <= mem_rdata_y;
          cap_dir   <= mem_rdata_dir;
        end
        ESCREVE: if (cap_ativo && fora) qtd <= qtd + (ADDR_W+1)'(1);
        PROXIMO: if (idx != ULTIMO) idx <= idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Moore outputs: state plus index/capture registers only, so a reset
  // pulls mem_we low in the same cycle it is asserted.
  always_comb begin
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_wdata_ativo = 1'b0;
    mem_wdata_x     = '0;
    mem_wdata_y     = '0;
    mem_wdata_dir   = '0;
    fim_move_tiros  = 1'b0;
    if (estado == LE || estado == CAPTURA || estado == ESCREVE) mem_addr = idx;
    if (estado == ESCREVE) begin
      mem_we          = cap_ativo;
      mem_wdata_ativo = cap_ativo & ~fora;
      mem_wdata_x     = nx;
      mem_wdata_y     = ny;
      mem_wdata_dir   = cap_dir;
    end
    if (estado == FIM) fim_move_tiros = 1'b1;
  end

  assign qtd_removidos        = qtd;
  assign db_estado_move_tiros = estado_db(estado);

endmodule

// File: tb/tb_move_tiros.sv
module tb_move_tiros;

  typedef struct packed {
    logic       ativo;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] dir;
  } shot_t;

  typedef struct {
    int    slot;
    shot_t init;
    shot_t exp;
    int    rem;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       movimenta_tiro = 1'b0;
  logic       fim_move_tiros;
  logic [2:0] mem_addr;
  logic       mem_we;
  logic       mem_wdata_ativo;
  logic [3:0] mem_wdata_x, mem_wdata_y;
  logic [2:0] mem_wdata_dir;
  logic       mem_rdata_ativo;
  logic [3:0] mem_rdata_x, mem_rdata_y;
  logic [2:0] mem_rdata_dir;
  logic [3:0] qtd_removidos;
  logic [3:0] db_estado_move_tiros;

  move_tiros dut (
    .clock                (clock),
    .reset                (reset),
    .movimenta_tiro       (movimenta_tiro),
    .fim_move_tiros       (fim_move_tiros),
    .mem_addr             (mem_addr),
    .mem_we               (mem_we),
    .mem_wdata_ativo      (mem_wdata_ativo),
    .mem_wdata_x          (mem_wdata_x),
    .mem_wdata_y          (mem_wdata_y),
    .mem_wdata_dir        (mem_wdata_dir),
    .mem_rdata_ativo      (mem_rdata_ativo),
    .mem_rdata_x          (mem_rdata_x),
    .mem_rdata_y          (mem_rdata_y),
    .mem_rdata_dir        (mem_rdata_dir),
    .qtd_removidos        (qtd_removidos),
    .db_estado_move_tiros (db_estado_move_tiros)
  );

  always #5 clock = ~clock;

  // Shot RAM model: synchronous read, one-cycle latency; bench preload port.
  shot_t      ram [8];
  shot_t      rd;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  shot_t      ld_dat = '0;

  always @(posedge clock) begin
    rd <= ram[mem_addr];
    if (ld_en) ram[ld_addr] <= ld_dat;
    else if (mem_we) ram[mem_addr] <= {mem_wdata_ativo, mem_wdata_x, mem_wdata_y, mem_wdata_dir};
  end
  assign {mem_rdata_ativo, mem_rdata_x, mem_rdata_y, mem_rdata_dir} = rd;

  int checks = 0;
  int errors = 0;
  int fim_cyc, fim_cnt, wr_cnt;
  vec_t vecs [13];

  function automatic shot_t mk(input int a, input int x, input int y, input int d);
    shot_t s;
    s.ativo = a[0];
    s.x     = x[3:0];
    s.y     = y[3:0];
    s.dir   = d[2:0];
    return s;
  endfunction

  function automatic shot_t bg(input int i);
    return mk(0, i, i + 1, i);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input shot_t s);
    ld_en = 1'b1;
    ld_addr = a[2:0];
    ld_dat = s;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 8; i++) load(i, bg(i));
  endtask

  task automatic wait_espera();
    for (int i = 0; i < 40 && db_estado_move_tiros != 4'h1; i++) tick();
    check("idle_espera", int'(db_estado_move_tiros), 1);
  endtask

  // Start pulse sampled in cycle 0; watch cycles 1..40 for fim and writes.
  task automatic run_once(input int extra_start);
    wait_espera();
    movimenta_tiro = 1'b1;
    tick();
    movimenta_tiro = 1'b0;
    fim_cyc = -1;
    fim_cnt = 0;
    wr_cnt  = 0;
    for (int c = 1; c <= 40; c++) begin
      movimenta_tiro = (c == extra_start);
      if (fim_move_tiros) begin
        fim_cnt++;
        if (fim_cyc < 0) fim_cyc = c;
      end
      if (mem_we) wr_cnt++;
      tick();
    end
    movimenta_tiro = 1'b0;
  endtask

  initial begin
    int bad;

    vecs[0]  = '{2, mk(1, 5, 5, 3),   mk(1, 6, 6, 3),   0};
    vecs[1]  = '{4, mk(1, 0, 9, 4),   mk(1, 0, 10, 4),  0};
    vecs[2]  = '{5, mk(1, 3, 0, 0),   mk(0, 3, 0, 0),   1};
    vecs[3]  = '{0, mk(1, 15, 7, 2),  mk(0, 15, 7, 2),  1};
    vecs[4]  = '{7, mk(1, 0, 0, 7),   mk(0, 0, 0, 7),   1};
    vecs[5]  = '{1, mk(1, 7, 7, 5),   mk(1, 6, 8, 5),   0};
    vecs[6]  = '{3, mk(1, 15, 15, 3), mk(0, 15, 15, 3), 1};
    vecs[7]  = '{6, mk(1, 0, 15, 6),  mk(0, 0, 15, 6),  1};
    vecs[8]  = '{6, mk(1, 1, 15, 6),  mk(1, 0, 15, 6),  0};
    vecs[9]  = '{1, mk(0, 4, 4, 1),   mk(0, 4, 4, 1),   0};
    vecs[10] = '{2, mk(1, 15, 0, 1),  mk(0, 15, 0, 1),  1};
    vecs[11] = '{3, mk(1, 14, 1, 1),  mk(1, 15, 0, 1),  0};
    vecs[12] = '{0, mk(1, 8, 8, 7),   mk(1, 7, 7, 7),   0};

    // Reset state
    #1;
    check("rst_db",   int'(db_estado_move_tiros), 0);
    check("rst_fim",  int'(fim_move_tiros), 0);
    check("rst_we",   int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_qtd",  int'(qtd_removidos), 0);
    @(negedge clock);
    reset = 1'b0;

    // All slots inactive
    clear_ram();
    run_once(0);
    check("empty_fim_cyc", fim_cyc, 33);
    check("empty_fim_cnt", fim_cnt, 1);
    check("empty_writes",  wr_cnt, 0);
    check("empty_qtd",     int'(qtd_removidos), 0);

    // Single-slot table
    for (int v = 0; v < 13; v++) begin
      clear_ram();
      load(vecs[v].slot, vecs[v].init);
      run_once(0);
      check($sformatf("v%0d_fim_cyc", v), fim_cyc, 33);
      check($sformatf("v%0d_writes", v), wr_cnt, int'(vecs[v].init.ativo));
      check($sformatf("v%0d_slot", v), int'(ram[vecs[v].slot]), int'(vecs[v].exp));
      check($sformatf("v%0d_qtd", v), int'(qtd_removidos), vecs[v].rem);
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (i != vecs[v].slot && ram[i] != bg(i)) bad++;
      check($sformatf("v%0d_others", v), bad, 0);
    end

    // Two slots leaving the field; count holds while idle
    clear_ram();
    load(0, mk(1, 15, 7, 2));
    load(7, mk(1, 0, 0, 7));
    run_once(0);
    check("two_slot0",  int'(ram[0]), int'(mk(0, 15, 7, 2)));
    check("two_slot7",  int'(ram[7]), int'(mk(0, 0, 0, 7)));
    check("two_writes", wr_cnt, 2);
    check("two_qtd",    int'(qtd_removidos), 2);
    repeat (5) tick();
    check("two_qtd_hold", int'(qtd_removidos), 2);

    // Second start pulse during a run is ignored
    clear_ram();
    run_once(10);
    check("dup_fim_cnt", fim_cnt, 1);
    check("dup_fim_cyc", fim_cyc, 33);
    check("dup_state",   int'(db_estado_move_tiros), 1);

    // Start held high through FIM begins a new run from ESPERA
    wait_espera();
    movimenta_tiro = 1'b1;
    tick();
    movimenta_tiro = 1'b0;
    for (int c = 1; c < 33; c++) tick();
    check("held_fim", int'(fim_move_tiros), 1);
    movimenta_tiro = 1'b1;
    tick();
    check("held_espera", int'(db_estado_move_tiros), 1);
    tick();
    check("held_le", int'(db_estado_move_tiros), 2);
    movimenta_tiro = 1'b0;
    fim_cyc = -1;
    for (int c = 36; c <= 80; c++) begin
      tick();
      if (fim_move_tiros && fim_cyc < 0) fim_cyc = c;
    end
    check("held_fim2_cyc", fim_cyc, 67);

    // Reset in ESCREVE of slot 3
    for (int i = 0; i < 8; i++) load(i, mk(1, 5, 5, 2));
    wait_espera();
    movimenta_tiro = 1'b1;
    tick();
    movimenta_tiro = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    check("abort_pre_db", int'(db_estado_move_tiros), 4);
    check("abort_pre_we", int'(mem_we), 1);
    reset = 1'b1;
    #1;
    check("abort_we",  int'(mem_we), 0);
    check("abort_db",  int'(db_estado_move_tiros), 0);
    check("abort_qtd", int'(qtd_removidos), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      check($sformatf("abort_slot%0d", i), int'(ram[i]),
            int'(i < 3 ? mk(1, 6, 5, 2) : mk(1, 5, 5, 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
